// File: rtl/iob_axistream_tb_src_pkg.sv
// Shared definitions for the simulation AXI-Stream source: FSM encodings and LFSR constants.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package iob_axistream_tb_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Galois feedback taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
  // An all-zero LFSR would lock up, so a zero seed is swapped for this value
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

  // One Galois step: shift right, fold the taps in when a one falls out
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/iob_axistream_tb_lfsr.sv
// 32-bit Galois LFSR used as the data generator in LFSR mode.
// Latency: new state visible one cycle after load_i or step_i.
// Backpressure: none; the caller only steps on accepted beats. Load wins over step.
module iob_axistream_tb_lfsr
  import iob_axistream_tb_src_pkg::*;
(
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        cke_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;

  // Load the (zero-substituted) seed, or advance one step per request
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= 32'h0;
    end else if (cke_i) begin
      if (load_i) begin
        state_q <= (seed_i == 32'h0) ? LFSR_ZERO_SUB : seed_i;
      end else if (step_i) begin
        state_q <= lfsr_step(state_q);
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/iob_axistream_tb_src.sv
// Simulation AXI-Stream source: frames of incrementing or LFSR data with idle gaps between frames.
// Latency: tvalid rises the cycle after start_i; done_o pulses the cycle after the final accepted beat.
// Backpressure: tdata/tlast hold while tvalid & !tready; sequence advances only on accepted beats.
module iob_axistream_tb_src
  import iob_axistream_tb_src_pkg::*;
#(
  parameter int TDATA_W     = 32,
  parameter int FRAME_LEN_W = 16,
  parameter int NFRAMES_W   = 16,
  parameter int GAP_W       = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [31:0]            seed_i,
  input  logic [FRAME_LEN_W-1:0] frame_len_i,
  input  logic [NFRAMES_W-1:0]   nframes_i,
  input  logic [GAP_W-1:0]       gap_i,
  output logic                   axis_tvalid_o,
  output logic [TDATA_W-1:0]     axis_tdata_o,
  output logic                   axis_tlast_o,
  input  logic                   axis_tready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            beat_cnt_o
);

  localparam logic [FRAME_LEN_W-1:0] LEN_ONE = FRAME_LEN_W'(1);
  localparam logic [NFRAMES_W-1:0]   NF_ONE  = NFRAMES_W'(1);
  localparam logic [GAP_W-1:0]       GAP_ONE = GAP_W'(1);

  state_t                 state_q, state_d;
  logic                   mode_q;
  logic [TDATA_W-1:0]     incr_q;
  logic [FRAME_LEN_W-1:0] frame_len_q, beat_q;
  logic [NFRAMES_W-1:0]   nframes_q, frame_q;
  logic [GAP_W-1:0]       gap_q, gap_cnt_q;
  logic [31:0]            beat_cnt_q;
  logic [31:0]            lfsr_state;

  logic start_ok, accept, last_beat, last_frame, gap_end;

  assign start_ok   = (state_q == ST_IDLE) && start_i;
  assign accept     = (state_q == ST_SEND) && axis_tready_i;
  assign last_beat  = (beat_q == frame_len_q - LEN_ONE);
  assign last_frame = (frame_q == nframes_q - NF_ONE);
  assign gap_end    = (gap_cnt_q == gap_q - GAP_ONE);

  iob_axistream_tb_lfsr u_lfsr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .load_i   (start_ok),
    .seed_i   (seed_i),
    .step_i   (accept),
    .state_o  (lfsr_state)
  );

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  // Next-state decode: empty runs go straight to DONE, zero gap keeps frames back-to-back
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if ((frame_len_i == '0) || (nframes_i == '0)) state_d = ST_DONE;
          else                                          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept && last_beat) begin
          if (last_frame)          state_d = ST_DONE;
          else if (gap_q == '0)    state_d = ST_SEND;
          else                     state_d = ST_GAP;
        end
      end
      ST_GAP:  if (gap_end) state_d = ST_SEND;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration, data generator and beat/frame/gap counters
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mode_q      <= 1'b0;
      incr_q      <= '0;
      frame_len_q <= '0;
      nframes_q   <= '0;
      gap_q       <= '0;
      beat_q      <= '0;
      frame_q     <= '0;
      gap_cnt_q   <= '0;
      beat_cnt_q  <= 32'h0;
    end else if (cke_i) begin
      if (start_ok) begin
        mode_q      <= mode_i;
        incr_q      <= seed_i[TDATA_W-1:0];
        frame_len_q <= frame_len_i;
        nframes_q   <= nframes_i;
        gap_q       <= gap_i;
        beat_q      <= '0;
        frame_q     <= '0;
        gap_cnt_q   <= '0;
      end
      if (accept) begin
        incr_q     <= incr_q + TDATA_W'(1);
        beat_cnt_q <= beat_cnt_q + 32'd1;
        if (last_beat) begin
          beat_q  <= '0;
          frame_q <= frame_q + NF_ONE;
        end else begin
          beat_q  <= beat_q + LEN_ONE;
        end
      end
      if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_end ? '0 : gap_cnt_q + GAP_ONE;
      end
    end
  end

  assign axis_tvalid_o = (state_q == ST_SEND);
  assign axis_tdata_o  = mode_q ? lfsr_state[TDATA_W-1:0] : incr_q;
  assign axis_tlast_o  = axis_tvalid_o && last_beat;
  assign busy_o        = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done_o        = (state_q == ST_DONE);
  assign beat_cnt_o    = beat_cnt_q;

endmodule

// File: tb/tb_iob_axistream_tb_src.sv
// Directed bench for the AXI-Stream source: incrementing/LFSR data, gaps, stalls, empty runs, reset.
// Latency: inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpressure: tready patterns are applied by the collect task.
module tb_iob_axistream_tb_src;

  logic        clk = 1'b0;
  logic        arst_n, cke, start, mode, tready;
  logic [31:0] seed;
  logic [15:0] frame_len, nframes;
  logic [7:0]  gap;
  logic        tvalid, tlast, busy, done;
  logic [31:0] tdata, beat_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] got_dat[$];
  logic        got_last[$];
  logic        got_vld[$];

  always #5 clk = ~clk;

  iob_axistream_tb_src dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .cke_i         (cke),
    .start_i       (start),
    .mode_i        (mode),
    .seed_i        (seed),
    .frame_len_i   (frame_len),
    .nframes_i     (nframes),
    .gap_i         (gap),
    .axis_tvalid_o (tvalid),
    .axis_tdata_o  (tdata),
    .axis_tlast_o  (tlast),
    .axis_tready_i (tready),
    .busy_o        (busy),
    .done_o        (done),
    .beat_cnt_o    (beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic start_run(input logic m, input logic [31:0] s, input logic [15:0] len,
                           input logic [15:0] nf, input logic [7:0] g);
    @(negedge clk);
    mode = m; seed = s; frame_len = len; nframes = nf; gap = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step cycles until done_o, recording accepted beats and tvalid per cycle.
  // pat 0: tready always 1; pat 1: tready 1,0,0 repeating. Stalled beats must hold.
  task automatic collect(input int pat, input int max_cyc, output int done_cyc);
    logic [31:0] pdat;
    logic        plast, pstall;
    got_dat.delete(); got_last.delete(); got_vld.delete();
    done_cyc = -1;
    pstall   = 1'b0;
    pdat     = 32'h0;
    plast    = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i > 0) @(negedge clk);
      tready = (pat == 0) ? 1'b1 : ((i % 3) == 0);
      if (done) begin
        done_cyc = i;
        chkb("done_tvalid", tvalid, 1'b0);
        chkb("done_busy", busy, 1'b0);
        break;
      end
      got_vld.push_back(tvalid);
      if (pstall) begin
        chk("stall_hold_tdata", tdata, pdat);
        chkb("stall_hold_tlast", tlast, plast);
        chkb("stall_hold_tvalid", tvalid, 1'b1);
      end
      if (tvalid && tready) begin
        got_dat.push_back(tdata);
        got_last.push_back(tlast);
      end
      pstall = tvalid && !tready;
      pdat   = tdata;
      plast  = tlast;
    end
    chkb("run_reached_done", done_cyc >= 0, 1'b1);
  endtask

  initial begin
    int          dc;
    logic [31:0] r;

    arst_n = 1'b0; cke = 1'b1; start = 1'b0; mode = 1'b0; tready = 1'b0;
    seed = 32'h0; frame_len = 16'h0; nframes = 16'h0; gap = 8'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chkb("rst_tvalid", tvalid, 1'b0);
    chk ("rst_tdata", tdata, 32'h0);
    chkb("rst_tlast", tlast, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chk ("rst_beat_cnt", beat_cnt, 32'h0);
    arst_n = 1'b1;

    // 1: incrementing, one frame of four, always ready
    tready = 1'b1;
    start_run(1'b0, 32'h10, 16'd4, 16'd1, 8'd0);
    chkb("t1_latency_tvalid", tvalid, 1'b1);
    chkb("t1_busy", busy, 1'b1);
    collect(0, 50, dc);
    chk("t1_done_cyc", 32'(dc), 32'd4);
    chk("t1_nbeats", 32'(got_dat.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk ("t1_tdata", got_dat[k], 32'h10 + 32'(k));
      chkb("t1_tlast", got_last[k], k == 3);
    end
    @(negedge clk);
    chkb("t1_done_one_cycle", done, 1'b0);
    chk ("t1_beat_cnt", beat_cnt, 32'd4);

    // 2: two frames of three with a two-cycle gap
    start_run(1'b0, 32'h13, 16'd3, 16'd2, 8'd2);
    collect(0, 50, dc);
    chk("t2_done_cyc", 32'(dc), 32'd8);
    chk("t2_vld_trace", 32'({got_vld[0], got_vld[1], got_vld[2], got_vld[3],
                             got_vld[4], got_vld[5], got_vld[6], got_vld[7]}), 32'b1110_0111);
    chk("t2_nbeats", 32'(got_dat.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk ("t2_tdata", got_dat[k], 32'h13 + 32'(k));
      chkb("t2_tlast", got_last[k], (k == 2) || (k == 5));
    end
    chk("t2_beat_cnt", beat_cnt, 32'd10);

    // 3: tready 1,0,0 pattern, two frames of two, gap 1
    start_run(1'b0, 32'h100, 16'd2, 16'd2, 8'd1);
    collect(1, 80, dc);
    chk("t3_done_cyc", 32'(dc), 32'd10);
    chk("t3_nbeats", 32'(got_dat.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk ("t3_tdata", got_dat[k], 32'h100 + 32'(k));
      chkb("t3_tlast", got_last[k], (k == 1) || (k == 3));
    end
    chk("t3_beat_cnt", beat_cnt, 32'd14);

    // 4: LFSR with zero seed, 64 beats against a reference model
    start_run(1'b1, 32'h0, 16'd64, 16'd1, 8'd0);
    collect(0, 200, dc);
    chk("t4_nbeats", 32'(got_dat.size()), 32'd64);
    chk("t4_beat0", got_dat[0], 32'h0000_0001);
    chk("t4_beat1", got_dat[1], 32'h8020_0003);
    chk("t4_beat2", got_dat[2], 32'hC030_0002);
    r = 32'h1;
    for (int k = 0; k < 64; k++) begin
      chk("t4_lfsr_model", got_dat[k], r);
      r = (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
    end
    chkb("t4_tlast_final", got_last[63], 1'b1);
    chk ("t4_beat_cnt", beat_cnt, 32'd78);

    // 5: empty runs finish immediately without sending
    start_run(1'b0, 32'h55, 16'd0, 16'd3, 8'd0);
    chkb("t5_len0_done", done, 1'b1);
    chkb("t5_len0_tvalid", tvalid, 1'b0);
    chkb("t5_len0_busy", busy, 1'b0);
    @(negedge clk);
    chkb("t5_len0_done_pulse", done, 1'b0);
    chkb("t5_len0_tvalid_after", tvalid, 1'b0);
    start_run(1'b0, 32'h55, 16'd4, 16'd0, 8'd0);
    chkb("t5_nf0_done", done, 1'b1);
    chkb("t5_nf0_tvalid", tvalid, 1'b0);
    chk ("t5_beat_cnt", beat_cnt, 32'd78);

    // 5b: start while busy is ignored
    start_run(1'b0, 32'h200, 16'd3, 16'd1, 8'd0);
    tready = 1'b0;
    @(negedge clk);
    mode = 1'b1; seed = 32'h999; frame_len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk ("t5_busy_tdata", tdata, 32'h200);
    chkb("t5_busy_tvalid", tvalid, 1'b1);
    chkb("t5_busy_tlast", tlast, 1'b0);
    collect(0, 50, dc);
    chk("t5_busy_nbeats", 32'(got_dat.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk ("t5_busy_tdata_seq", got_dat[k], 32'h200 + 32'(k));
      chkb("t5_busy_tlast_seq", got_last[k], k == 2);
    end
    chk("t5_busy_beat_cnt", beat_cnt, 32'd81);

    // 6: async reset mid-frame, then a clean run (with a clock-enable freeze)
    start_run(1'b0, 32'h300, 16'd5, 16'd1, 8'd0);
    tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_reset_tdata", tdata, 32'h302);
    #2 arst_n = 1'b0;
    #1;
    chkb("t6_rst_tvalid", tvalid, 1'b0);
    chkb("t6_rst_busy", busy, 1'b0);
    chkb("t6_rst_tlast", tlast, 1'b0);
    chk ("t6_rst_beat_cnt", beat_cnt, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chkb("t6_rst_no_done", done, 1'b0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    chkb("t6_idle_after_rst", busy, 1'b0);
    chkb("t6_no_done_after_rst", done, 1'b0);

    start_run(1'b0, 32'h400, 16'd2, 16'd1, 8'd0);
    cke = 1'b0;
    tready = 1'b1;
    repeat (3) @(negedge clk);
    chk ("t6_cke_tdata", tdata, 32'h400);
    chkb("t6_cke_tvalid", tvalid, 1'b1);
    chk ("t6_cke_beat_cnt", beat_cnt, 32'h0);
    cke = 1'b1;
    collect(0, 50, dc);
    chk("t6_nbeats", 32'(got_dat.size()), 32'd2);
    for (int k = 0; k < 2; k++) begin
      chk ("t6_tdata", got_dat[k], 32'h400 + 32'(k));
      chkb("t6_tlast", got_last[k], k == 1);
    end
    chk("t6_beat_cnt", beat_cnt, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
